// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: control-bit indices, EX field offsets,
// control-group structs and the hard-wired zero register number.
package mips_pkg;

    localparam int unsigned WB_W  = 2;
    localparam int unsigned MEM_W = 3;

    // WB group bit indices: {reg_write, mem_to_reg}
    localparam int unsigned WB_REGWR = 1;
    localparam int unsigned WB_M2R   = 0;

    // MEM group bit indices: {branch, mem_read, mem_write}
    localparam int unsigned MEM_BR = 2;
    localparam int unsigned MEM_RD = 1;
    localparam int unsigned MEM_WR = 0;

    // EX group layout: {reg_dst, alu_op[ALUOP_W-1:0], alu_src}; reg_dst sits at ALUOP_W+1
    localparam int unsigned EX_ALUSRC    = 0;
    localparam int unsigned EX_ALUOP_LSB = 1;

    // $zero is never a real hazard source
    localparam int unsigned REG_ZERO = 0;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;

    typedef struct packed {
        logic branch;
        logic mem_read;
        logic mem_write;
    } mem_ctrl_t;

endpackage

// File: rtl/id_ex_hazard_unit.sv
// Load-use hazard detector (purely combinational).
// Ports:
//   i_ex_valid, i_ex_mem_rd, i_ex_dest : load instruction currently in EX
//   i_id_valid, i_id_uses_rt, i_id_rs, i_id_rt : consumer instruction in ID
//   i_flush    : a flushed ID instruction never raises a hazard
//   o_load_use_c : hold PC and IF/ID, insert a bubble into EX
module id_ex_hazard_unit
    import mips_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic              i_ex_valid,
    input  logic              i_ex_mem_rd,
    input  logic [REG_AW-1:0] i_ex_dest,
    input  logic              i_id_valid,
    input  logic              i_id_uses_rt,
    input  logic [REG_AW-1:0] i_id_rs,
    input  logic [REG_AW-1:0] i_id_rt,
    input  logic              i_flush,
    output logic              o_load_use_c
);

    logic w_dest_nz;
    logic w_rs_hit;
    logic w_rt_hit;

    assign w_dest_nz = (i_ex_dest != REG_AW'(REG_ZERO));
    assign w_rs_hit  = (i_ex_dest == i_id_rs);
    assign w_rt_hit  = i_id_uses_rt & (i_ex_dest == i_id_rt);

    assign o_load_use_c = i_ex_valid & i_ex_mem_rd & w_dest_nz & i_id_valid & ~i_flush &
                          (w_rs_hit | w_rt_hit);

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register with valid bit, downstream stall, flush and
// built-in load-use bubble insertion.
// Optional feature: define ID_EX_PERF_EN for saturating bubble/stall counters.
// Ports:
//   clock, reset_n          : clock, async active-low reset
//   stall, flush            : hold all state / turn next EX content into a bubble
//   id_*                    : decoded instruction, control groups and operands
//   ex_*                    : registered EX-stage copy; control zero in a bubble
//   ex_dest                 : combinational write-back register select
//   load_use_stall          : combinational, hold PC and IF/ID this cycle
//   perf_bubbles/perf_stalls: event counters (zero when feature disabled)
module id_ex_pipe_reg
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned ALUOP_W = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               stall,
    input  logic               flush,
    input  logic               id_valid,
    input  logic               id_uses_rt,
    input  logic [1:0]         id_wb,
    input  logic [2:0]         id_mem,
    input  logic [ALUOP_W+1:0] id_ex,
    input  logic [DATA_W-1:0]  id_pc,
    input  logic [DATA_W-1:0]  id_rs_data,
    input  logic [DATA_W-1:0]  id_rt_data,
    input  logic [DATA_W-1:0]  id_imm,
    input  logic [REG_AW-1:0]  id_rs,
    input  logic [REG_AW-1:0]  id_rt,
    input  logic [REG_AW-1:0]  id_rd,
    output logic               ex_valid,
    output logic [1:0]         ex_wb,
    output logic [2:0]         ex_mem,
    output logic               ex_alu_src,
    output logic               ex_reg_dst,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic [DATA_W-1:0]  ex_pc,
    output logic [DATA_W-1:0]  ex_rs_data,
    output logic [DATA_W-1:0]  ex_rt_data,
    output logic [DATA_W-1:0]  ex_imm,
    output logic [REG_AW-1:0]  ex_rs,
    output logic [REG_AW-1:0]  ex_rt,
    output logic [REG_AW-1:0]  ex_rd,
    output logic [REG_AW-1:0]  ex_dest,
    output logic               load_use_stall,
    output logic [CNT_W-1:0]   perf_bubbles,
    output logic [CNT_W-1:0]   perf_stalls
);

    localparam int unsigned EX_W      = ALUOP_W + 2;
    localparam int unsigned EX_REGDST = ALUOP_W + 1;

    logic              r_valid;
    wb_ctrl_t          r_wb;
    mem_ctrl_t         r_mem;
    logic [EX_W-1:0]   r_ex;
    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [DATA_W-1:0] r_imm;
    logic [REG_AW-1:0] r_rs;
    logic [REG_AW-1:0] r_rt;
    logic [REG_AW-1:0] r_rd;

    logic              w_load_use;
    logic              w_hold;
    logic              w_bubble;
    logic [REG_AW-1:0] w_dest;

    assign w_dest = r_ex[EX_REGDST] ? r_rd : r_rt;

    id_ex_hazard_unit #(.REG_AW(REG_AW)) u_hazard (
        .i_ex_valid   (r_valid),
        .i_ex_mem_rd  (r_mem.mem_read),
        .i_ex_dest    (w_dest),
        .i_id_valid   (id_valid),
        .i_id_uses_rt (id_uses_rt),
        .i_id_rs      (id_rs),
        .i_id_rt      (id_rt),
        .i_flush      (flush),
        .o_load_use_c (w_load_use)
    );

    // Flush outranks stall; stall outranks the load-use bubble.
    assign w_hold   = ~flush & stall;
    assign w_bubble = flush | (~stall & w_load_use);

    // Data/address fields always follow ID when not held; only control is squashed.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid   <= 1'b0;
            r_wb      <= '0;
            r_mem     <= '0;
            r_ex      <= '0;
            r_pc      <= '0;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_imm     <= '0;
            r_rs      <= '0;
            r_rt      <= '0;
            r_rd      <= '0;
        end else if (!w_hold) begin
            r_pc      <= id_pc;
            r_rs_data <= id_rs_data;
            r_rt_data <= id_rt_data;
            r_imm     <= id_imm;
            r_rs      <= id_rs;
            r_rt      <= id_rt;
            r_rd      <= id_rd;
            if (w_bubble || !id_valid) begin
                r_valid <= 1'b0;
                r_wb    <= '0;
                r_mem   <= '0;
                r_ex    <= '0;
            end else begin
                r_valid <= 1'b1;
                r_wb    <= wb_ctrl_t'(id_wb);
                r_mem   <= mem_ctrl_t'(id_mem);
                r_ex    <= id_ex;
            end
        end
    end

    assign ex_valid       = r_valid;
    assign ex_wb          = r_wb;
    assign ex_mem         = r_mem;
    assign ex_alu_src     = r_ex[EX_ALUSRC];
    assign ex_reg_dst     = r_ex[EX_REGDST];
    assign ex_alu_op      = r_ex[EX_ALUOP_LSB +: ALUOP_W];
    assign ex_pc          = r_pc;
    assign ex_rs_data     = r_rs_data;
    assign ex_rt_data     = r_rt_data;
    assign ex_imm         = r_imm;
    assign ex_rs          = r_rs;
    assign ex_rt          = r_rt;
    assign ex_rd          = r_rd;
    assign ex_dest        = w_dest;
    assign load_use_stall = w_load_use;

`ifdef ID_EX_PERF_EN
    logic [CNT_W-1:0] r_perf_bubbles;
    logic [CNT_W-1:0] r_perf_stalls;

    // Saturating event counters, cleared only by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_perf_bubbles <= '0;
            r_perf_stalls  <= '0;
        end else begin
            if (!w_hold && w_bubble && (r_perf_bubbles != '1))
                r_perf_bubbles <= r_perf_bubbles + CNT_W'(1);
            if (w_hold && (r_perf_stalls != '1))
                r_perf_stalls <= r_perf_stalls + CNT_W'(1);
        end
    end

    assign perf_bubbles = r_perf_bubbles;
    assign perf_stalls  = r_perf_stalls;
`else
    assign perf_bubbles = '0;
    assign perf_stalls  = '0;
`endif

endmodule
